vga_sync_porch: RTL and testbench
=================================

Name: vga_sync_porch

Overview:
- Downstream stage of the VGA sync-pulse generator.
- Consumes its active-region flags (high while col < ACTIVE_COLS / row < ACTIVE_ROWS) plus pixel data from the pattern/video source.
- Re-derives its own col/row count by locking to the frame start, then emits real VGA sync pulses with front/back porches and blanked, latency-aligned RGB for the DAC pins.

Parameters:
- TOTAL_COLS, 800, clocks per line.
- TOTAL_ROWS, 525, lines per frame.
- ACTIVE_COLS, 640, visible pixels per line.
- ACTIVE_ROWS, 480, visible lines per frame.
- H_FRONT_PORCH, 16, clocks between end of active and hsync pulse.
- H_BACK_PORCH, 48, clocks between end of hsync pulse and line end.
- V_FRONT_PORCH, 10, lines between end of active and vsync pulse.
- V_BACK_PORCH, 33, lines between end of vsync pulse and frame end.
- VIDEO_WIDTH, 3, bits per colour channel.

Ports:
- clock  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- ihsync  in  1  horizontal active flag from upstream.
- ivsync  in  1  vertical active flag from upstream.
- ired  in  VIDEO_WIDTH  pixel red, same cycle as the flags.
- igreen  in  VIDEO_WIDTH  pixel green.
- iblue  in  VIDEO_WIDTH  pixel blue.
- ohsync  out  1  VGA hsync, active-low pulse.
- ovsync  out  1  VGA vsync, active-low pulse.
- ored  out  VIDEO_WIDTH  blanked, delayed red.
- ogreen  out  VIDEO_WIDTH  blanked, delayed green.
- oblue  out  VIDEO_WIDTH  blanked, delayed blue.
- olocked  out  1  counter is locked to upstream frame.
- olock_err  out  1  one-cycle pulse on detected misalignment.

Behaviour:
- Reset (asynchronous, reset_n=0): ohsync=1, ovsync=1, all RGB outputs=0, olocked=0, olock_err=0, internal col_c=0 and row_c=0, state=UNLOCKED.
  - Input-flag history registers h_d and v_d reset to 1, so a reset released mid-frame needs a genuine low-to-high transition before locking.
- Edge detection:
  - frame_start = ivsync & ~v_d.
  - line_start = ihsync & ~h_d.
  - h_d and v_d register ihsync and ivsync every clock.
- Counter stage (register 1):
  - On frame_start: col_c<=0, row_c<=0.
  - Otherwise col_c increments; at TOTAL_COLS-1 it wraps to 0 and row_c increments, wrapping at TOTAL_ROWS-1.
  - Result: col_c/row_c equal the upstream position delayed one clock.
  - Counters are 10 bits, unsigned; compares are against parameter expressions only.
- State machine:
  - UNLOCKED: counters run, but outputs are held idle (ohsync=1, ovsync=1, RGB=0). The first frame_start moves to LOCKED.
  - LOCKED: frame_start while the counter is not about to wrap to (0,0), i.e. not at (TOTAL_COLS-1, TOTAL_ROWS-1):
    - counters reload to (0,0);
    - olock_err pulses for 1 cycle;
    - state stays LOCKED.
  - LOCKED: line_start while col_c != TOTAL_COLS-1: olock_err pulses for 1 cycle; no reload.
  - Simultaneous frame_start and line_start are reported as a single error pulse.
  - olocked is registered: 1 in the cycle after entering LOCKED.
- Output stage (register 2, driven from col_c/row_c):
  - ohsync=0 iff ACTIVE_COLS+H_FRONT_PORCH <= col_c < TOTAL_COLS-H_BACK_PORCH. Default: 656..751, 96 clocks.
  - ovsync=0 iff ACTIVE_ROWS+V_FRONT_PORCH <= row_c < TOTAL_ROWS-V_BACK_PORCH. Default: rows 490..491, for whole lines.
  - RGB is the input delayed 2 clocks. It is forced to 0 when col_c >= ACTIVE_COLS or row_c >= ACTIVE_ROWS, or when UNLOCKED.
- Latency: 2 clocks from input flags/RGB to ohsync/ovsync/RGB. All outputs are fully registered.
- Out-of-range parameters (porches exceeding the blanking interval) are unsupported; no runtime check.

Decomposition:
- Shared package vga_timing_pkg holds:
  - 640x480@60 constants (totals, actives, four porches);
  - the derived sync start/end expressions;
  - the lock state enum (UNLOCKED, LOCKED).
- One sub-module, vga_sync_to_count, contains the edge detectors, the col/row counters, the lock FSM and olock_err.
- The top level holds the porch compares and the RGB delay/blank pipeline.

Test Plan:
- Reset then feed from the upstream generator (defaults): olocked=1 by 3 clocks after the first upstream (col 0, row 0). Measured ohsync low width=96 clocks, period=800. ovsync low 2 lines (1600 clocks), period 420000.
- Constant RGB=3'b111 input: outputs 7 exactly on the active region, 2 clocks delayed, 640x480 pixels per frame. Outputs 0 during the porches and sync.
- Release reset_n while ivsync=1 (mid-active): no lock and idle outputs until ivsync drops and rises again, then lock.
- Inject an early ivsync rising edge 5 clocks before the expected frame start: one olock_err pulse, counters reload, next frame timing is correct with no further errors.
- Assert reset_n=0 mid-sync pulse: ohsync/ovsync go to 1 and RGB to 0 asynchronously, olocked=0.
- Suppress one ihsync line's rising edge: no error. Shift one ihsync rising edge by 1 clock: exactly one olock_err pulse, counters unchanged.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, sync-window helpers and the lock state type
// for the VGA sync/porch output stage.
package vga_timing_pkg;

    localparam int DEF_TOTAL_COLS    = 800;
    localparam int DEF_TOTAL_ROWS    = 525;
    localparam int DEF_ACTIVE_COLS   = 640;
    localparam int DEF_ACTIVE_ROWS   = 480;
    localparam int DEF_H_FRONT_PORCH = 16;
    localparam int DEF_H_BACK_PORCH  = 48;
    localparam int DEF_V_FRONT_PORCH = 10;
    localparam int DEF_V_BACK_PORCH  = 33;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Sync pulse occupies [sync_start, sync_end) on the local counter.
    function automatic int sync_start(input int active, input int front_porch);
        return active + front_porch;
    endfunction

    function automatic int sync_end(input int total, input int back_porch);
        return total - back_porch;
    endfunction

endpackage

// File: rtl/vga_sync_to_count.sv
// Locks a local col/row counter to the upstream active flags and reports
// misaligned frame/line starts.
module vga_sync_to_count
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS = DEF_TOTAL_ROWS
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ihsync,
    input  logic       ivsync,
    output logic [9:0] col_c,
    output logic [9:0] row_c,
    output logic       locked_c,
    output logic       olocked,
    output logic       olock_err
);

    localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);

    lock_state_t state;
    logic        h_d;
    logic        v_d;
    logic        frame_start;
    logic        line_start;
    logic        at_wrap;
    logic        err_c;

    assign frame_start = ivsync & ~v_d;
    assign line_start  = ihsync & ~h_d;
    assign at_wrap     = (col_c == COL_LAST) && (row_c == ROW_LAST);
    assign locked_c    = (state == LOCKED);
    // Frame and line errors in the same cycle collapse into one pulse.
    assign err_c       = locked_c && ((frame_start && !at_wrap) ||
                                      (line_start && (col_c != COL_LAST)));

    // Counter stage: col_c/row_c trail the upstream position by one clock
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_d       <= 1'b1;
            v_d       <= 1'b1;
            col_c     <= '0;
            row_c     <= '0;
            state     <= UNLOCKED;
            olocked   <= 1'b0;
            olock_err <= 1'b0;
        end else begin
            h_d       <= ihsync;
            v_d       <= ivsync;
            olock_err <= err_c;
            olocked   <= locked_c;
            if (frame_start) begin
                col_c <= '0;
                row_c <= '0;
                state <= LOCKED;
            end else if (col_c == COL_LAST) begin
                col_c <= '0;
                row_c <= (row_c == ROW_LAST) ? 10'd0 : row_c + 10'd1;
            end else begin
                col_c <= col_c + 10'd1;
            end
        end
    end

endmodule

// File: rtl/vga_sync_porch.sv
// VGA output stage: regenerates hsync/vsync with porches from the locked counter
// and emits blanked RGB aligned two clocks behind the upstream inputs.
module vga_sync_porch
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS    = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
    parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
    parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
    parameter int H_BACK_PORCH  = DEF_H_BACK_PORCH,
    parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
    parameter int V_BACK_PORCH  = DEF_V_BACK_PORCH,
    parameter int VIDEO_WIDTH   = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ihsync,
    input  logic                   ivsync,
    input  logic [VIDEO_WIDTH-1:0] ired,
    input  logic [VIDEO_WIDTH-1:0] igreen,
    input  logic [VIDEO_WIDTH-1:0] iblue,
    output logic                   ohsync,
    output logic                   ovsync,
    output logic [VIDEO_WIDTH-1:0] ored,
    output logic [VIDEO_WIDTH-1:0] ogreen,
    output logic [VIDEO_WIDTH-1:0] oblue,
    output logic                   olocked,
    output logic                   olock_err
);

    localparam logic [9:0] H_SYNC_START = 10'(sync_start(ACTIVE_COLS, H_FRONT_PORCH));
    localparam logic [9:0] H_SYNC_END   = 10'(sync_end(TOTAL_COLS, H_BACK_PORCH));
    localparam logic [9:0] V_SYNC_START = 10'(sync_start(ACTIVE_ROWS, V_FRONT_PORCH));
    localparam logic [9:0] V_SYNC_END   = 10'(sync_end(TOTAL_ROWS, V_BACK_PORCH));
    localparam logic [9:0] H_ACTIVE     = 10'(ACTIVE_COLS);
    localparam logic [9:0] V_ACTIVE     = 10'(ACTIVE_ROWS);

    logic [9:0]               col_c;
    logic [9:0]               row_c;
    logic                     locked_c;
    logic [3*VIDEO_WIDTH-1:0] rgb_p1;
    logic                     visible_c;

    vga_sync_to_count #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS)
    ) u_count (
        .clock     (clock),
        .reset_n   (reset_n),
        .ihsync    (ihsync),
        .ivsync    (ivsync),
        .col_c     (col_c),
        .row_c     (row_c),
        .locked_c  (locked_c),
        .olocked   (olocked),
        .olock_err (olock_err)
    );

    assign visible_c = locked_c && (col_c < H_ACTIVE) && (row_c < V_ACTIVE);

    // Stage 1: pixel data registered alongside the counter stage
    always_ff @(posedge clock) begin
        rgb_p1 <= {ired, igreen, iblue};
    end

    // Stage 2: sync windows and blanking from the counter position
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ohsync <= 1'b1;
            ovsync <= 1'b1;
            ored   <= '0;
            ogreen <= '0;
            oblue  <= '0;
        end else begin
            ohsync <= !(locked_c && (col_c >= H_SYNC_START) && (col_c < H_SYNC_END));
            ovsync <= !(locked_c && (row_c >= V_SYNC_START) && (row_c < V_SYNC_END));
            if (visible_c) begin
                {ored, ogreen, oblue} <= rgb_p1;
            end else begin
                {ored, ogreen, oblue} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_porch.sv
// Bench for vga_sync_porch using a shrunken 20x12 frame driven by an upstream
// generator model, with a linear-position reference model checked every cycle.
module tb_vga_sync_porch;

    localparam int TC  = 20;
    localparam int TR  = 12;
    localparam int AC  = 12;
    localparam int AR  = 8;
    localparam int HFP = 2;
    localparam int HBP = 3;
    localparam int VFP = 1;
    localparam int VBP = 2;
    localparam int F   = TC * TR;
    localparam int HSS = AC + HFP;
    localparam int HSE = TC - HBP;
    localparam int VSS = AR + VFP;
    localparam int VSE = TR - VBP;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       ihsync, ivsync;
    logic [2:0] ired, igreen, iblue;
    logic       ohsync, ovsync;
    logic [2:0] ored, ogreen, oblue;
    logic       olocked, olock_err;

    vga_sync_porch #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_FRONT_PORCH(HFP), .H_BACK_PORCH(HBP), .V_FRONT_PORCH(VFP),
        .V_BACK_PORCH(VBP), .VIDEO_WIDTH(3)
    ) dut (
        .clock(clock), .reset_n(reset_n), .ihsync(ihsync), .ivsync(ivsync),
        .ired(ired), .igreen(igreen), .iblue(iblue),
        .ohsync(ohsync), .ovsync(ovsync), .ored(ored), .ogreen(ogreen), .oblue(oblue),
        .olocked(olocked), .olock_err(olock_err)
    );

    always #5 clock = ~clock;

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: the counter is a linear frame position 0..F-1.
    bit       m_locked, m_hprev, m_vprev;
    int       m_pos;
    bit [8:0] m_rgb_prev;
    bit       exp_hs, exp_vs, exp_olocked, exp_err;
    bit [8:0] exp_rgb;

    task model_reset();
        m_locked = 0; m_pos = 0; m_hprev = 1; m_vprev = 1; m_rgb_prev = '0;
        exp_hs = 1; exp_vs = 1; exp_rgb = '0; exp_olocked = 0; exp_err = 0;
    endtask

    task automatic model_step();
        bit fs, ls;
        int col, row;
        fs  = ivsync && !m_vprev;
        ls  = ihsync && !m_hprev;
        col = m_pos % TC;
        row = m_pos / TC;
        exp_err     = m_locked && ((fs && m_pos != F - 1) || (ls && col != TC - 1));
        exp_hs      = !(m_locked && col >= HSS && col < HSE);
        exp_vs      = !(m_locked && row >= VSS && row < VSE);
        exp_rgb     = (m_locked && col < AC && row < AR) ? m_rgb_prev : 9'd0;
        exp_olocked = m_locked;
        if (fs) m_locked = 1;
        m_pos      = fs ? 0 : (m_pos + 1) % F;
        m_hprev    = ihsync;
        m_vprev    = ivsync;
        m_rgb_prev = {ired, igreen, iblue};
    endtask

    always @(posedge clock) begin
        if (!reset_n) model_reset();
        else model_step();
        #1;
        chk("cycle", int'({ohsync, ovsync, ored, ogreen, oblue, olocked, olock_err}),
            int'({exp_hs, exp_vs, exp_rgb, exp_olocked, exp_err}));
    end

    // Upstream generator and output statistics, both on the falling edge.
    int  ucol, urow, cyc, t00, t_lock;
    bit  rgb_rand, early_pending, supp_pending, shift_pending;
    int  supp_row, shift_row;
    bit  prev_hs, prev_vs;
    int  hrun, vrun, h_width, v_width, h_period, v_period, last_hfall, last_vfall;
    int  pix_cnt, err_cnt;

    task reset_stats();
        prev_hs = 1; prev_vs = 1; hrun = 0; vrun = 0;
        h_width = -1; v_width = -1; h_period = -1; v_period = -1;
        last_hfall = -1; last_vfall = -1; pix_cnt = 0; err_cnt = 0;
    endtask

    task tick();
        @(negedge clock);
        cyc++;
        if (prev_hs && !ohsync) begin
            if (last_hfall >= 0) h_period = cyc - last_hfall;
            last_hfall = cyc; hrun = 0;
        end
        if (!ohsync) hrun++;
        if (!prev_hs && ohsync) h_width = hrun;
        prev_hs = ohsync;
        if (prev_vs && !ovsync) begin
            if (last_vfall >= 0) v_period = cyc - last_vfall;
            last_vfall = cyc; vrun = 0;
        end
        if (!ovsync) vrun++;
        if (!prev_vs && ovsync) v_width = vrun;
        prev_vs = ovsync;
        if ({ored, ogreen, oblue} == 9'h1FF) pix_cnt++;
        if (olock_err) err_cnt++;
        if (olocked && t_lock < 0) t_lock = cyc;

        ihsync = (ucol < AC);
        ivsync = (urow < AR);
        if (supp_pending && urow == supp_row && ucol < AC) begin
            ihsync = 0;
            if (ucol == AC - 1) supp_pending = 0;
        end
        if (shift_pending && urow == shift_row && ucol == 0) begin
            ihsync = 0;
            shift_pending = 0;
        end
        if (rgb_rand) begin
            ired   = 3'($urandom_range(0, 7));
            igreen = 3'($urandom_range(0, 7));
            iblue  = 3'($urandom_range(0, 7));
        end else begin
            ired = 3'd7; igreen = 3'd7; iblue = 3'd7;
        end
        if (ucol == 0 && urow == 0 && t00 < 0) t00 = cyc;

        if (early_pending && urow * TC + ucol == F - 6) begin
            ucol = 0; urow = 0; early_pending = 0;
        end else if (ucol == TC - 1) begin
            ucol = 0;
            urow = (urow == TR - 1) ? 0 : urow + 1;
        end else begin
            ucol++;
        end
    endtask

    task run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n = 0;
        model_reset();
        ihsync = 1; ivsync = 1; ired = 0; igreen = 0; iblue = 0;
        ucol = 5; urow = 3; cyc = 0; t00 = -1; t_lock = -1;
        rgb_rand = 0; early_pending = 0; supp_pending = 0; shift_pending = 0;
        supp_row = 3; shift_row = 5;
        reset_stats();

        run(4);
        chk("reset_outputs", int'({ohsync, ovsync, ored, ogreen, oblue, olocked, olock_err}),
            int'({1'b1, 1'b1, 9'd0, 1'b0, 1'b0}));

        // Release mid-frame with ivsync high: lock must wait for the next frame start.
        reset_n = 1;
        for (int i = 0; i < 2 * F && t_lock < 0; i++) tick();
        chk("lock_seen", int'(t_lock >= 0 && t00 >= 0), 1);
        chk("lock_latency", t_lock - t00, 2);

        run(2 * F);
        reset_stats();
        run(2 * F);
        chk("hsync_width", h_width, HSE - HSS);
        chk("hsync_period", h_period, TC);
        chk("vsync_width", v_width, (VSE - VSS) * TC);
        chk("vsync_period", v_period, F);
        reset_stats();
        run(F);
        chk("active_pixels", pix_cnt, AC * AR);
        chk("no_err_steady", err_cnt, 0);

        rgb_rand = 1;
        run(2 * F);

        reset_stats();
        early_pending = 1;
        run(3 * F);
        chk("early_frame_err", err_cnt, 1);
        chk("early_period_ok", v_period, F);

        reset_stats();
        supp_pending = 1;
        run(2 * F);
        chk("suppressed_line_err", err_cnt, 0);

        reset_stats();
        shift_pending = 1;
        run(2 * F);
        chk("shifted_line_err", err_cnt, 1);
        chk("shifted_hperiod", h_period, TC);

        // Asynchronous reset while hsync is low.
        begin
            bit found;
            found = 0;
            for (int i = 0; i < 2 * F && !found; i++) begin
                tick();
                if (!ohsync) found = 1;
            end
            chk("hsync_low_found", int'(found), 1);
        end
        #2;
        reset_n = 0;
        model_reset();
        #1;
        chk("async_reset", int'({ohsync, ovsync, ored, ogreen, oblue, olocked, olock_err}),
            int'({1'b1, 1'b1, 9'd0, 1'b0, 1'b0}));
        run(3);
        reset_n = 1;
        run(F + F / 2);
        chk("relocked", int'(olocked), 1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
